// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: owns the PC, resolves B/BR in ID against Z/V/N, freezes on HLT.
// Optional statistics counters are built when PC_STATS_EN is defined.
module pc_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_reg,
  input  logic [2:0]  br_cond,
  input  logic [8:0]  br_imm,
  input  logic [15:0] br_rs_val,
  input  logic [15:0] id_pc_plus2,
  input  logic [2:0]  flags,
  input  logic        flags_ready,
  input  logic        hlt_dec,
  output logic [15:0] pc,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        br_taken,
  output logic        halted,
  output logic [15:0] br_cnt,
  output logic [15:0] taken_cnt,
  output logic [15:0] wait_cnt
);

  typedef enum logic [1:0] {RUN, FLAG_WAIT, HALT} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc_nxt;

  // flags are {Z,V,N}
  function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] f);
    logic z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (cond)
      3'b000:  cond_met = !z;
      3'b001:  cond_met = z;
      3'b010:  cond_met = !z && !n;
      3'b011:  cond_met = n;
      3'b100:  cond_met = z || (!z && !n);
      3'b101:  cond_met = z || n;
      3'b110:  cond_met = v;
      default: cond_met = 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] b_target(input logic [15:0] base, input logic [8:0] imm);
    logic signed [15:0] off;
    off      = {{6{imm[8]}}, imm, 1'b0};
    b_target = base + $unsigned(off);
  endfunction

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc + 16'd2;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    br_taken    = 1'b0;
    case (state)
      RUN, FLAG_WAIT: begin
        if (stall) begin
          state_nxt = state;
        end else if (hlt_dec) begin
          state_nxt   = HALT;
          if_id_flush = 1'b1;
        end else if (br_valid && !flags_ready && br_cond != 3'b111) begin
          state_nxt = FLAG_WAIT;
        end else begin
          // Resolved branch or plain sequential fetch
          state_nxt   = RUN;
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          if (br_valid && cond_met(br_cond, flags)) begin
            br_taken    = 1'b1;
            if_id_flush = 1'b1;
            pc_nxt      = br_reg ? br_rs_val : b_target(id_pc_plus2, br_imm);
          end
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (pc_write) pc <= pc_nxt;
    end
  end

  assign halted = (state == HALT);

`ifdef PC_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt    <= 16'h0000;
      taken_cnt <= 16'h0000;
      wait_cnt  <= 16'h0000;
    end else begin
      if (pc_write && br_valid) br_cnt <= sat_inc(br_cnt);
      if (br_taken) taken_cnt <= sat_inc(taken_cnt);
      if (state == FLAG_WAIT) wait_cnt <= sat_inc(wait_cnt);
    end
  end
`else
  assign br_cnt    = 16'h0000;
  assign taken_cnt = 16'h0000;
  assign wait_cnt  = 16'h0000;
`endif

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch-stage PC sequencer for the 16-bit WISC pipeline. It owns the PC register and resolves B/BR branches in ID against the Z/V/N flags. It waits in place when the flags are not yet valid and squashes the wrong-path IF/ID instruction on a taken branch. It also freezes fetch on HLT and merges hazard-unit stalls into a single PC/IF-ID write decision.

## Interface
Parameters:
- RESET_PC, 16'h0000, fetch address loaded on reset

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hazard-unit stall; hold PC and IF/ID
- br_valid  input  1  ID holds a B or BR instruction
- br_reg  input  1  1 = BR (register target), 0 = B (immediate)
- br_cond  input  3  condition code from instruction
- br_imm  input  9  B offset in halfwords, signed
- br_rs_val  input  16  BR target register value (forwarded)
- id_pc_plus2  input  16  PC+2 of the instruction in ID
- flags  input  3  {Z,V,N} as seen by ID
- flags_ready  input  1  no flag-writing instruction still in flight
- hlt_dec  input  1  ID holds HLT
- pc  output  16  fetch address (registered)
- pc_write  output  1  PC updates this edge
- if_id_write  output  1  IF/ID latch enable
- if_id_flush  output  1  zero IF/ID this edge
- br_taken  output  1  branch resolved taken this cycle
- halted  output  1  HLT reached, fetch frozen
- br_cnt / taken_cnt / wait_cnt  output  16 each  statistics (see Configuration)

## Operation
- States: RUN, FLAG_WAIT, HALT. Reset forces RUN, pc=RESET_PC, halted=0, all counters 0.
- Priority in RUN and FLAG_WAIT: stall > hlt_dec > branch > sequential.
- stall=1: pc_write=0, if_id_write=0, no flush, state unchanged.
- RUN, hlt_dec=1:
  - next state HALT, pc_write=0.
  - if_id_flush=1 squashes the instruction after HLT.
- RUN, br_valid=1, flags_ready=0 (B only; BR ignores flags only when br_cond=111):
  - next state FLAG_WAIT.
  - pc_write=0, if_id_write=0.
- Resolution, in RUN with flags_ready=1 or in FLAG_WAIT when flags_ready rises:
  - taken is evaluated from br_cond and flags.
  - Taken: pc<=target, br_taken=1, if_id_flush=1, return RUN.
  - Not taken: pc<=pc+2, return RUN.
- Condition codes:
  - 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1.
  - 100 Z=1|(Z=0&N=0); 101 Z=1|N=1; 110 V=1; 111 always.
- Target:
  - B: id_pc_plus2 + (sign-extended br_imm << 1), modulo 2^16.
  - BR: br_rs_val.
- Sequential: pc<=pc+2 (wraps 16'hFFFE→16'h0000), if_id_write=1.
- HALT:
  - pc_write=0, if_id_write=0, halted=1.
  - Ignores all inputs and exits only on rst.
- br_cond=111 with flags_ready=0 resolves immediately; flags are not needed.

## Timing
- pc, state, halted and counters are registered.
- pc_write, if_id_write, if_id_flush and br_taken are combinational from state and inputs in the same cycle.
- Taken-branch penalty: 1 bubble (flushed wrong-path fetch). Each FLAG_WAIT cycle adds 1 more.
- halted asserts the cycle after hlt_dec is accepted.
- rst wins over every input in any state, including mid-FLAG_WAIT. The next cycle shows pc=RESET_PC, RUN.
- stall during FLAG_WAIT holds FLAG_WAIT even if flags_ready=1. Resolution happens on the first cycle with stall=0 and flags_ready=1.

## Configuration
- PC_STATS_EN defined:
  - br_cnt increments on each resolved branch.
  - taken_cnt increments on each taken branch.
  - wait_cnt increments on each FLAG_WAIT cycle.
  - All three are 16-bit, saturate at 16'hFFFF and clear on rst.
- Not defined: the three ports still exist and are tied to 16'h0000, with no counter logic.

## Test plan
- Reset then 4 idle cycles → pc 0000,0002,0004,0006,0008; if_id_write=1; no flush.
- B at id_pc_plus2=0x0010, br_imm=9'h1FE (−2), br_cond=001, flags=3'b100, flags_ready=1 → br_taken=1, if_id_flush=1, next pc=0x000C.
- Same B with flags_ready=0 for 2 cycles, then flags=3'b000 → 2 cycles with pc held and pc_write=0, then not taken and pc+2. With PC_STATS_EN: wait_cnt=2, br_cnt=1, taken_cnt=0.
- BR, br_cond=111, br_rs_val=0xBEEF, flags_ready=0 → taken same cycle, pc=0xBEEF.
- hlt_dec with stall=1 for 1 cycle, then stall=0 → cycle 1 holds state. Cycle 2 flushes IF/ID, then halted=1 and pc frozen for 10 cycles. rst then returns pc=RESET_PC and halted=0.
- pc=0xFFFE sequential → pc=0x0000. stall and br_valid together → no PC change and no resolution.
